// File: rtl/mem_sram_arbiter.sv
// mem_sram_arbiter: round-robin arbiter sharing one single-port 256b-wide SRAM bank
// among N_CLIENTS requesters. It issues at most one access per cycle and drops
// accesses whose bank id does not match, turning them into a one-cycle error pulse.
// Read data returns one cycle after the grant. A client can hold the bank for a
// locked burst of up to MAX_BURST beats.
`timescale 1ns/1ps
module mem_sram_arbiter #(
    parameter int unsigned N_CLIENTS = 4,
    parameter int unsigned BANK_ID   = 0,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CLIENTS-1:0]      cl_req,
    input  logic [N_CLIENTS-1:0]      cl_we,
    input  logic [N_CLIENTS-1:0]      cl_lock,
    input  logic [N_CLIENTS*19-1:0]   cl_addr,
    input  logic [N_CLIENTS*256-1:0]  cl_wdata,
    output logic [N_CLIENTS-1:0]      cl_gnt,
    output logic [N_CLIENTS-1:0]      cl_rvalid,
    output logic [255:0]              cl_rdata,
    output logic [N_CLIENTS-1:0]      cl_err,
    output logic                      sram_cs,
    output logic [3:0]                sram_id,
    output logic                      sram_read,
    output logic                      sram_write,
    output logic [18:0]               sram_addr,
    output logic [255:0]              sram_din,
    input  logic [255:0]              sram_dout
);

    localparam int          NC    = int'(N_CLIENTS);
    localparam int unsigned IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam logic [3:0]  BANK  = 4'(BANK_ID);
    localparam logic [8:0]  MAXB  = 9'(MAX_BURST);

    // Registered state
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic                 lock_act_q, lock_act_d;
    logic [7:0]           beat_cnt_q, beat_cnt_d;
    logic                 rd_pend_q, rd_pend_d;
    logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
    logic [N_CLIENTS-1:0] err_q, err_d;

    // Winner selection results
    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand;
    logic [18:0]          win_addr;
    logic [255:0]         win_wdata;
    logic                 win_we;
    logic                 win_lock;
    logic                 bank_ok;
    logic [8:0]           beat_inc;

    // Pick the winner: locked owner first, otherwise round-robin after the last winner.
    // Nothing is granted while reset is held.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        if (!rst) begin
            if (lock_act_q && cl_req[owner_q]) begin
                win_found = 1'b1;
                win_idx   = owner_q;
            end else begin
                for (int k = 1; k <= NC; k++) begin
                    cand = IDX_W'((int'(ptr_q) + k) % NC);
                    if (!win_found && cl_req[cand]) begin
                        win_found = 1'b1;
                        win_idx   = cand;
                    end
                end
            end
        end
    end

    // Route the winner's request fields and drive the grant / SRAM strobes.
    always_comb begin
        win_addr  = '0;
        win_wdata = '0;
        win_we    = 1'b0;
        win_lock  = 1'b0;
        cl_gnt    = '0;
        for (int i = 0; i < NC; i++) begin
            if (win_found && win_idx == IDX_W'(i)) begin
                win_addr  = cl_addr[i*19 +: 19];
                win_wdata = cl_wdata[i*256 +: 256];
                win_we    = cl_we[i];
                win_lock  = cl_lock[i];
                cl_gnt[i] = 1'b1;
            end
        end
        bank_ok    = (win_addr[18:15] == BANK);
        sram_cs    = win_found && bank_ok;
        sram_read  = win_found && bank_ok && !win_we;
        sram_write = win_found && bank_ok && win_we;
        sram_addr  = win_addr;
        sram_din   = win_wdata;
        sram_id    = BANK;
    end

    // Next-state: pointer, burst lock bookkeeping, read-return and error pipeline.
    always_comb begin
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        lock_act_d = lock_act_q;
        beat_cnt_d = beat_cnt_q;
        rd_pend_d  = 1'b0;
        rd_idx_d   = rd_idx_q;
        err_d      = '0;
        beat_inc   = '0;

        // Owner walked away from its burst: release the lock.
        if (lock_act_q && !cl_req[owner_q]) begin
            lock_act_d = 1'b0;
            beat_cnt_d = '0;
        end

        if (win_found) begin
            ptr_d = win_idx;
            if (win_lock) begin
                // beat_cnt_d is zero unless the owner is continuing its burst.
                beat_inc = {1'b0, beat_cnt_d} + 9'd1;
                if (beat_inc >= MAXB) begin
                    lock_act_d = 1'b0;
                    beat_cnt_d = '0;
                end else begin
                    lock_act_d = 1'b1;
                    owner_d    = win_idx;
                    beat_cnt_d = beat_inc[7:0];
                end
            end else begin
                lock_act_d = 1'b0;
                beat_cnt_d = '0;
            end
            if (!bank_ok) begin
                err_d = cl_gnt;
            end
        end

        if (sram_read) begin
            rd_pend_d = 1'b1;
            rd_idx_d  = win_idx;
        end
    end

    // State register; reset gives client 0 top priority and drops pending responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= IDX_W'(N_CLIENTS - 1);
            owner_q    <= '0;
            lock_act_q <= 1'b0;
            beat_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            rd_idx_q   <= '0;
            err_q      <= '0;
        end else begin
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            lock_act_q <= lock_act_d;
            beat_cnt_q <= beat_cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_idx_q   <= rd_idx_d;
            err_q      <= err_d;
        end
    end

    // Response side: one-hot read-valid for the client whose read issued last cycle.
    always_comb begin
        cl_rvalid = '0;
        for (int i = 0; i < NC; i++) begin
            cl_rvalid[i] = rd_pend_q && (rd_idx_q == IDX_W'(i));
        end
        cl_rdata = sram_dout;
        cl_err   = err_q;
    end

endmodule

// File: tb/tb_mem_sram_arbiter.sv
// Directed bench for mem_sram_arbiter (4 clients, bank id 3, burst limit 8).
`timescale 1ns/1ps
module tb_mem_sram_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, we, lock;
    logic [N*19-1:0] addr;
    logic [N*256-1:0] wdata;
    logic [N-1:0]    gnt, rvalid, err;
    logic [255:0]    rdata, din, dout;
    logic            cs, rd, wr;
    logic [3:0]      id;
    logic [18:0]     saddr;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_sram_arbiter #(.N_CLIENTS(N), .BANK_ID(3), .MAX_BURST(8)) dut (
        .clk(clk), .rst(rst),
        .cl_req(req), .cl_we(we), .cl_lock(lock),
        .cl_addr(addr), .cl_wdata(wdata),
        .cl_gnt(gnt), .cl_rvalid(rvalid), .cl_rdata(rdata), .cl_err(err),
        .sram_cs(cs), .sram_id(id), .sram_read(rd), .sram_write(wr),
        .sram_addr(saddr), .sram_din(din), .sram_dout(dout)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge (input drive point).
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle sample point, well away from both clock edges.
    task automatic settle();
        #3;
    endtask

    function automatic logic [18:0] mk_addr(input logic [3:0] bank, input logic [9:0] line);
        return {bank, line, 5'b0};
    endfunction

    logic [3:0] g_tab [6];
    logic [3:0] v_tab [6];

    initial begin
        rst   = 1'b1;
        req   = '0;
        we    = '0;
        lock  = '0;
        addr  = '0;
        wdata = '0;
        dout  = '0;

        // ---------------- reset state ----------------
        cyc(); settle();
        chk("rst_gnt",    256'(gnt),    256'h0);
        chk("rst_rvalid", 256'(rvalid), 256'h0);
        chk("rst_err",    256'(err),    256'h0);
        chk("rst_cs",     256'(cs),     256'h0);
        chk("rst_id",     256'(id),     256'h3);
        chk("rst_addr",   256'(saddr),  256'h0);

        for (int i = 0; i < N; i++) begin
            addr[i*19 +: 19]   = mk_addr(4'd3, 10'(i + 1));
            wdata[i*256 +: 256] = {8{32'hA000_0000 + 32'(i)}};
        end
        cyc();
        rst = 1'b0;

        // ---------------- 1: single read from client 2 ----------------
        cyc();
        addr[2*19 +: 19] = 19'h18040;
        req = 4'b0100;
        settle();
        chk("t1_gnt",   256'(gnt),   256'h4);
        chk("t1_cs",    256'(cs),    256'h1);
        chk("t1_read",  256'(rd),    256'h1);
        chk("t1_write", 256'(wr),    256'h0);
        chk("t1_addr",  256'(saddr), 256'h18040);
        cyc();
        req  = '0;
        dout = {8{32'hDEAD_0001}};
        settle();
        chk("t1_rvalid", 256'(rvalid), 256'h4);
        chk("t1_rdata",  rdata, {8{32'hDEAD_0001}});
        chk("t1_gnt_idle", 256'(gnt), 256'h0);

        // ---------------- 2: all request, client 1 writes ----------------
        // last winner was 2, so rotation goes 3,0,1,2,3,0
        g_tab = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        v_tab = '{4'b0000, 4'b1000, 4'b0001, 4'b0000, 4'b0100, 4'b1000};
        for (int k = 0; k < 6; k++) begin
            cyc();
            req = 4'b1111;
            we  = 4'b0010;
            settle();
            chk($sformatf("t2_gnt%0d", k),    256'(gnt),    256'(g_tab[k]));
            chk($sformatf("t2_rvalid%0d", k), 256'(rvalid), 256'(v_tab[k]));
            chk($sformatf("t2_write%0d", k),  256'(wr),     256'(g_tab[k] == 4'b0010));
        end
        cyc();
        req = 4'b0010;
        we  = 4'b0010;
        settle();
        chk("t2_rvalid_last", 256'(rvalid), 256'h1);
        chk("t2_wr_din", din, {8{32'hA000_0001}});
        chk("t2_wr_strobe", 256'(wr), 256'h1);
        cyc();
        req = '0;
        we  = '0;
        settle();
        chk("t2_no_rvalid_after_write", 256'(rvalid), 256'h0);

        // ---------------- 3: wrong bank id ----------------
        cyc();
        addr[0*19 +: 19] = mk_addr(4'd5, 10'd7);
        req = 4'b0001;
        settle();
        chk("t3_gnt",  256'(gnt), 256'h1);
        chk("t3_cs",   256'(cs),  256'h0);
        chk("t3_read", 256'(rd),  256'h0);
        chk("t3_err_now", 256'(err), 256'h0);
        cyc();
        req = '0;
        addr[0*19 +: 19] = mk_addr(4'd3, 10'd1);
        settle();
        chk("t3_err",    256'(err),    256'h1);
        chk("t3_rvalid", 256'(rvalid), 256'h0);
        cyc(); settle();
        chk("t3_err_gone", 256'(err), 256'h0);

        // ---------------- 4: client 1 locked burst, limit 8 ----------------
        for (int k = 0; k < 9; k++) begin
            cyc();
            req  = 4'b1111;
            lock = 4'b0010;
            settle();
            chk($sformatf("t4_gnt%0d", k), 256'(gnt), (k < 8) ? 256'h2 : 256'h4);
        end
        cyc();
        req  = '0;
        lock = '0;

        // ---------------- 5: client 3 lock released on 3rd beat ----------------
        for (int k = 0; k < 4; k++) begin
            cyc();
            req  = 4'b1111;
            lock = (k < 2) ? 4'b1000 : 4'b0000;
            settle();
            chk($sformatf("t5_gnt%0d", k), 256'(gnt), (k < 3) ? 256'h8 : 256'h1);
        end
        cyc();
        req  = '0;
        lock = '0;

        // ---------------- 6: reset right after a read grant ----------------
        cyc();
        req = 4'b0100;
        settle();
        chk("t6_gnt", 256'(gnt), 256'h4);
        cyc();
        req = '0;
        rst = 1'b1;
        settle();
        chk("t6_rvalid_dropped", 256'(rvalid), 256'h0);
        chk("t6_cs_in_rst",      256'(cs),     256'h0);
        cyc();
        rst = 1'b0;
        req = 4'b1111;
        settle();
        chk("t6_gnt_after_rst", 256'(gnt), 256'h1);
        cyc();
        req = '0;
        settle();
        chk("t6_rvalid_after_rst", 256'(rvalid), 256'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
